// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//   This block bridges one 32-bit MEM-stage load/store to a 16-bit
//   asynchronous SRAM. Each word is moved as two half-word phases, low half
//   first. A fixed number of idle wait cycles follows the two phases, and
//   then there is a single DONE cycle. While an access is in flight, `ready`
//   stays low and freezes the pipeline.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   wr_en/rd_en  store / load request (write wins when both are high)
//   address      byte address; ADDR_OFFSET is subtracted from it
//   wr_data      store value
//   rd_data      last completed read word
//   ready        1 = access complete or no request, 0 = freeze
//   sram_addr    half-word address to the SRAM
//   sram_dq_out  write data to the SRAM
//   sram_dq_oe   1 = controller drives the data bus
//   sram_dq_in   read data from the SRAM (combinational)
//   sram_we_n    active-low SRAM write enable
// ---------------------------------------------------------------------------
module sram_controller #(
  parameter int unsigned ADDR_OFFSET = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [16:0]      idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             is_wr_q, is_wr_d;
  logic [15:0]      lo_q, lo_d;
  logic [15:0]      hi_q, hi_d;
  logic [31:0]      rd_data_q, rd_data_d;

  // Only the word index survives. The byte lane and the bits above the
  // 2^19-byte SRAM window are dropped on purpose.
  logic [31:0] eff_s;
  logic        unused_eff_s;
  assign eff_s        = address - 32'(ADDR_OFFSET);
  assign unused_eff_s = ^{eff_s[31:19], eff_s[1:0]};

  // State register: all state clears on synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 17'd0;
      wdata_q   <= 32'd0;
      is_wr_q   <= 1'b0;
      lo_q      <= 16'd0;
      hi_q      <= 16'd0;
      rd_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next-state logic: request latching, phase counting and read-half capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (wr_en || rd_en) begin
          idx_d   = eff_s[18:2];
          wdata_d = wr_data;
          is_wr_d = wr_en;
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!is_wr_q && cnt_q == CNT_W'(0)) begin
          lo_d = sram_dq_in;
        end else if (!is_wr_q && cnt_q == CNT_W'(1)) begin
          hi_d = sram_dq_in;
        end else begin
          lo_d = lo_q;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          // Use the _d halves so that a zero-wait configuration, whose last
          // phase is the high-half capture, still assembles correctly.
          if (!is_wr_q) begin
            rd_data_d = {hi_d, lo_d};
          end else begin
            rd_data_d = rd_data_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // A request seen here is deliberately ignored and re-sampled in IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // SRAM pins and handshake, decoded from the current state and phase.
  always_comb begin
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    ready       = 1'b0;
    if (state_q == ACCESS && cnt_q == CNT_W'(0)) begin
      sram_addr = {idx_q, 1'b0};
      if (is_wr_q) begin
        sram_dq_out = wdata_q[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end else begin
        sram_dq_out = 16'd0;
      end
    end else if (state_q == ACCESS && cnt_q == CNT_W'(1)) begin
      sram_addr = {idx_q, 1'b1};
      if (is_wr_q) begin
        sram_dq_out = wdata_q[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end else begin
        sram_dq_out = 16'd0;
      end
    end else begin
      sram_addr = 18'd0;
    end
    case (state_q)
      IDLE:    ready = !(wr_en || rd_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
//   This is a directed bench for sram_controller at its default parameters,
//   connected to a small behavioural SRAM. Inputs are driven on the falling
//   edge and outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        mem_clr;

  int n_tests;
  int n_fail;

  logic [15:0] mem [0:255];

  sram_controller dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: the write is taken at the clock edge, and the read is combinational.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'd0;
    end else if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
    end
  end
  assign sram_dq_in = mem[sram_addr[7:0]];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // This runs one full access. The request is raised in cycle T and dropped
  // in T+1. exp_a0 is the low half-word address, and exp_rd is rd_data in T+6.
  task automatic access(input string tag, input logic w, input logic r,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [17:0] exp_a0, input logic [31:0] exp_rd);
    cyc();
    wr_en = w; rd_en = r; address = addr; wr_data = data;
    #1;
    check({tag, "_rdy_T"}, {31'd0, ready}, 32'd0);
    cyc();
    wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; wr_data = 32'h0;
    #1;
    check({tag, "_a0"}, {14'd0, sram_addr}, {14'd0, exp_a0});
    check({tag, "_we0"}, {31'd0, sram_we_n}, {31'd0, !w});
    check({tag, "_oe0"}, {31'd0, sram_dq_oe}, {31'd0, w});
    check({tag, "_dq0"}, {16'd0, sram_dq_out}, w ? {16'd0, data[15:0]} : 32'd0);
    check({tag, "_rdy1"}, {31'd0, ready}, 32'd0);
    cyc(); #1;
    check({tag, "_a1"}, {14'd0, sram_addr}, {14'd0, exp_a0 | 18'd1});
    check({tag, "_we1"}, {31'd0, sram_we_n}, {31'd0, !w});
    check({tag, "_dq1"}, {16'd0, sram_dq_out}, w ? {16'd0, data[31:16]} : 32'd0);
    for (int k = 3; k <= 5; k++) begin
      cyc(); #1;
      check({tag, "_rdy_wait"}, {31'd0, ready}, 32'd0);
      check({tag, "_we_wait"}, {31'd0, sram_we_n}, 32'd1);
      check({tag, "_a_wait"}, {14'd0, sram_addr}, 32'd0);
    end
    cyc(); #1;
    check({tag, "_rdy_done"}, {31'd0, ready}, 32'd1);
    check({tag, "_rd_data"}, rd_data, exp_rd);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; mem_clr = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; wr_data = 32'h0;
    cyc(); cyc();
    rst = 1'b0; mem_clr = 1'b0;
    cyc(); #1;
    // Check the reset state.
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_dq", {16'd0, sram_dq_out}, 32'd0);
    check("rst_rd_data", rd_data, 32'h0000_0000);

    // Write 0xDEADBEEF to 1028, which is word 1 (half-words 2 and 3).
    access("wr1028", 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h0);
    check("mem2", {16'd0, mem[2]}, 32'h0000BEEF);
    check("mem3", {16'd0, mem[3]}, 32'h0000DEAD);

    // Read the word back.
    access("rd1028", 1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF);

    // Both requests are high, so only a write happens and rd_data is kept.
    access("both1032", 1'b1, 1'b1, 32'd1032, 32'h12345678, 18'd4, 32'hDEADBEEF);
    check("mem4", {16'd0, mem[4]}, 32'h00005678);
    check("mem5", {16'd0, mem[5]}, 32'h00001234);
    access("rd1032", 1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'h12345678);

    // Byte lane and bits above bit 18 are dropped: eff = 0x80013 -> word 4 -> half-word 8.
    access("wrap", 1'b1, 1'b0, 32'd1024 + 32'h0008_0013, 32'h0BADF00D, 18'd8, 32'h12345678);
    check("mem8", {16'd0, mem[8]}, 32'h0000F00D);
    check("mem9", {16'd0, mem[9]}, 32'h00000BAD);

    // Reset in T+1 of a write to 1036 (half-words 6 and 7).
    cyc();
    wr_en = 1'b1; address = 32'd1036; wr_data = 32'hCAFE_F00D;
    cyc();
    wr_en = 1'b0; rst = 1'b1;
    #1;
    check("rmid_a0", {14'd0, sram_addr}, 32'd6);
    cyc();
    rst = 1'b0;
    #1;
    check("rmid_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rmid_ready", {31'd0, ready}, 32'd1);
    check("rmid_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rmid_addr", {14'd0, sram_addr}, 32'd0);
    check("rmid_rd_data", rd_data, 32'd0);
    cyc(); cyc(); #1;
    check("rmid_mem7", {16'd0, mem[7]}, 32'd0);

    // Hold the read request through DONE: one access, then a new one from the next IDLE cycle.
    cyc();
    rd_en = 1'b1; address = 32'd1028;
    #1;
    check("hold_rdy_T", {31'd0, ready}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(); #1;
      check("hold_rdy_busy", {31'd0, ready}, 32'd0);
    end
    cyc(); #1;
    check("hold_rdy_done", {31'd0, ready}, 32'd1);
    check("hold_rd_data", rd_data, 32'hDEADBEEF);
    cyc(); #1;
    check("hold_rdy_T7", {31'd0, ready}, 32'd0);
    check("hold_addr_T7", {14'd0, sram_addr}, 32'd0);
    cyc(); #1;
    check("hold_addr_T8", {14'd0, sram_addr}, 32'd2);
    for (int k = 9; k <= 12; k++) begin
      cyc(); #1;
      check("hold_rdy_busy2", {31'd0, ready}, 32'd0);
    end
    cyc(); #1;
    check("hold_rdy_done2", {31'd0, ready}, 32'd1);
    rd_en = 1'b0;
    cyc(); #1;
    check("hold_idle", {31'd0, ready}, 32'd1);
    check("hold_we_n", {31'd0, sram_we_n}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter ADDR_OFFSET, default 1024: base byte address of data memory, subtracted from address.
REQ-002 Parameter WAIT_CYCLES, default 3: idle wait cycles after the two half-word phases.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_en  input  1  MEM-stage write request.
REQ-006 rd_en  input  1  MEM-stage read request.
REQ-007 address  input  32  byte address from ALU result.
REQ-008 wr_data  input  32  store value.
REQ-009 rd_data  output  32  last completed read word.
REQ-010 ready  output  1  high = access complete or no request; low = pipeline freeze.
REQ-011 sram_addr  output  18  external SRAM half-word address.
REQ-012 sram_dq_out  output  16  write data to SRAM.
REQ-013 sram_dq_oe  output  1  high = controller drives the data bus.
REQ-014 sram_dq_in  input  16  read data from SRAM (asynchronous, combinational).
REQ-015 sram_we_n  output  1  SRAM write enable, active-low.

Function
REQ-016 The controller SHALL implement the states IDLE, ACCESS (counter cnt = 0..1+WAIT_CYCLES) and DONE.
REQ-017 In IDLE, wr_en or rd_en SHALL latch address, wr_data and the operation type, then transition to ACCESS with cnt=0 on the next edge.
REQ-018 When wr_en and rd_en are both high, the controller SHALL perform a write only.
REQ-019 Word index SHALL be eff[18:2], where eff = (address - ADDR_OFFSET) mod 2^32; address[1:0] ignored, upper bits truncated.
REQ-020 sram_addr SHALL be {eff[18:2],1'b0} at cnt=0, {eff[18:2],1'b1} at cnt=1, and 0 otherwise.
REQ-021 Write, cnt=0: sram_dq_out=wr_data[15:0], sram_we_n=0, sram_dq_oe=1.
REQ-022 Write, cnt=1: sram_dq_out=wr_data[31:16], sram_we_n=0, sram_dq_oe=1.
REQ-023 Outside write phases: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-024 Read: sram_dq_in SHALL be captured at the end of cnt=0 into an internal low half and at the end of cnt=1 into a high half.
REQ-025 On the ACCESS-to-DONE edge, rd_data SHALL load {high,low}; writes SHALL leave rd_data unchanged.
REQ-026 ACCESS SHALL advance cnt each cycle and transition to DONE after cnt = 1+WAIT_CYCLES; DONE SHALL return to IDLE after one cycle.
REQ-027 ready SHALL be combinational: 1 in DONE, 1 in IDLE with no request, otherwise 0.
REQ-028 Latency: with a request first seen in cycle T, ready SHALL be 0 in cycles T..T+2+WAIT_CYCLES and 1 in cycle T+3+WAIT_CYCLES (T+6 at defaults).
REQ-029 Request inputs deasserting or changing during ACCESS/DONE SHALL be ignored; the operation completes on latched values.
REQ-030 A request present in DONE SHALL NOT start an access; it is sampled again in IDLE.

Reset
REQ-031 rst high at an edge SHALL force IDLE and cnt=0, and clear rd_data, the latched values and the half-word registers to 0.
REQ-032 After reset, the outputs SHALL be ready=1 (if no request), sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
REQ-033 Reset mid-access SHALL abort immediately; any remaining half-word write phase SHALL NOT occur.

Verification (behavioural SRAM model, defaults)
REQ-034 Reset, no requests -> ready=1, sram_we_n=1, sram_dq_oe=0, rd_data=0x00000000.
REQ-035 Write 0xDEADBEEF to address 1028 in cycle T:
- T+1: sram_addr=2, sram_dq_out=0xBEEF, sram_we_n=0.
- T+2: sram_addr=3, sram_dq_out=0xDEAD, sram_we_n=0.
- ready=0 in T..T+5, ready=1 in T+6.
REQ-036 Read address 1028 after REQ-035 -> rd_data=0xDEADBEEF in T+6, sram_we_n=1 throughout; word 1 must contain 0xDEADBEEF.
REQ-037 wr_en=rd_en=1, address 1032, wr_data 0x12345678 -> SRAM half-words 4/5 = 0x5678/0x1234, rd_data unchanged.
REQ-038 rst asserted in T+1 of a write to 1036 -> next cycle IDLE, sram_we_n=1, ready=1; half-word 7 not written.
REQ-039 Request held high through DONE -> exactly one access, then a new 6-cycle access beginning in the following IDLE cycle.
